// File: rtl/plan_cmd_sequencer.sv
// plan_cmd_sequencer: buffers compact move commands and expands them into
// per-cycle one-hot direction strobes for the grid planner.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   cmd_valid/cmd_ready         command push handshake (ready = FIFO not full)
//   cmd_agent[1:0]              0 robot, 1 obs1, 2 obs2, 3 end-of-init marker
//   cmd_dir[1:0]                0 up, 1 down, 2 left, 3 right
//   cmd_rep[CNT_W-1:0]          strobe length minus one
//   robot_*/obs1_*/obs2_*       registered one-hot direction strobes
//   end_init                    level, set once the marker executes
//   robot_sel                   level, high alongside robot strobes
//   busy                        FIFO non-empty or a command executing
//   err_order                   sticky illegal-ordering flag
module plan_cmd_sequencer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_agent,
    input  logic [1:0]       cmd_dir,
    input  logic [CNT_W-1:0] cmd_rep,
    output logic             robot_up,
    output logic             robot_down,
    output logic             robot_left,
    output logic             robot_right,
    output logic             obs1_up,
    output logic             obs1_down,
    output logic             obs1_left,
    output logic             obs1_right,
    output logic             obs2_up,
    output logic             obs2_down,
    output logic             obs2_left,
    output logic             obs2_right,
    output logic             end_init,
    output logic             robot_sel,
    output logic             busy,
    output logic             err_order
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 4 + CNT_W;
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic {S_IDLE, S_EXEC} state_t;
    typedef enum logic {P_INIT, P_RUN} phase_t;

    // ------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------
    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic [EW-1:0]    head;
    logic [1:0]       h_agent;
    logic [1:0]       h_dir;
    logic [CNT_W-1:0] h_rep;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Full blocks the push even if the executor frees a slot this cycle.
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_agent, cmd_dir, cmd_rep};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    assign head    = mem[rd_ptr[AW-1:0]];
    assign h_agent = head[EW-1 -: 2];
    assign h_dir   = head[CNT_W +: 2];
    assign h_rep   = head[CNT_W-1:0];

    // ------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    phase_t           phase_q;
    phase_t           phase_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       agent_q;
    logic [1:0]       agent_d;
    logic [1:0]       dir_q;
    logic [1:0]       dir_d;
    logic             end_init_q;
    logic             end_init_d;
    logic             err_q;
    logic             err_d;

    logic             can_take;
    logic             in_init;
    logic             h_marker;
    logic             h_robot;
    logic             c_mark_ok;
    logic             c_mark_bad;
    logic             c_robot_bad;
    logic             c_move;

    assign in_init  = (phase_q == P_INIT);
    assign h_marker = (h_agent == 2'd3);
    assign h_robot  = (h_agent == 2'd0);

    // Mutually exclusive classification of the FIFO head.
    assign c_mark_ok   = h_marker && in_init;
    assign c_mark_bad  = h_marker && !in_init;
    assign c_robot_bad = h_robot && in_init;
    assign c_move      = !h_marker && !(h_robot && in_init);

    // The executor accepts a new command when idle or on the final
    // cycle of the current one, so commands chain without a bubble.
    assign can_take = (state_q == S_IDLE) || (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        agent_d    = agent_q;
        dir_d      = dir_q;
        end_init_d = end_init_q;
        err_d      = err_q;
        pop        = 1'b0;

        if (state_q == S_EXEC) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                state_d = S_IDLE;
            end
        end

        if (can_take && !empty) begin
            pop     = 1'b1;
            state_d = S_IDLE;
            unique case (1'b1)
                c_mark_ok: begin
                    phase_d    = P_RUN;
                    end_init_d = 1'b1;
                end
                c_mark_bad: begin
                    err_d = 1'b1;
                end
                c_robot_bad: begin
                    err_d = 1'b1;
                end
                c_move: begin
                    state_d = S_EXEC;
                    cnt_d   = h_rep;
                    agent_d = h_agent;
                    dir_d   = h_dir;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            phase_q    <= P_INIT;
            cnt_q      <= '0;
            agent_q    <= '0;
            dir_q      <= '0;
            end_init_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            agent_q    <= agent_d;
            dir_q      <= dir_d;
            end_init_q <= end_init_d;
            err_q      <= err_d;
        end
    end

    // ------------------------------------------------------------
    // Registered strobes: one cycle behind the executing state.
    // Bit index is {agent, dir}; agent 3 never reaches EXEC.
    // ------------------------------------------------------------
    logic [11:0] strb_d;
    logic [11:0] strb_q;
    logic        sel_d;
    logic        sel_q;

    always_comb begin
        strb_d = '0;
        sel_d  = 1'b0;
        if (state_q == S_EXEC) begin
            strb_d[{agent_q, dir_q}] = 1'b1;
            sel_d = (agent_q == 2'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_q <= '0;
            sel_q  <= 1'b0;
        end else begin
            strb_q <= strb_d;
            sel_q  <= sel_d;
        end
    end

    assign robot_up    = strb_q[0];
    assign robot_down  = strb_q[1];
    assign robot_left  = strb_q[2];
    assign robot_right = strb_q[3];
    assign obs1_up     = strb_q[4];
    assign obs1_down   = strb_q[5];
    assign obs1_left   = strb_q[6];
    assign obs1_right  = strb_q[7];
    assign obs2_up     = strb_q[8];
    assign obs2_down   = strb_q[9];
    assign obs2_left   = strb_q[10];
    assign obs2_right  = strb_q[11];

    assign robot_sel = sel_q;
    assign end_init  = end_init_q;
    assign err_order = err_q;
    assign busy      = !empty || (state_q == S_EXEC);

endmodule
